fifo_stream_reader: RTL and testbench

//  Read-side drain engine for the single-clock byte FIFO. Pops the FIFO (rd_en / registered

---
 rtl/fifo_pkg.sv | 14 +
 rtl/rd_skid_buf.sv | 60 ++++++
 rtl/fifo_stream_reader.sv | 67 ++++++
 tb/tb_fifo_stream_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the byte FIFO read path
package fifo_pkg;

  localparam int FIFO_DATA_W  = 8;
  localparam int RD_BUF_DEPTH = 3;

  typedef logic [1:0] occ_t;

  // Circular pointer advance over the RD_BUF_DEPTH entries (2 -> 0).
  function automatic occ_t ptr_inc(input occ_t p);
    return (p == occ_t'(RD_BUF_DEPTH - 1)) ? occ_t'(0) : p + occ_t'(1);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - 3-entry circular capture buffer between FIFO read data and the stream
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rdata_o,
  output occ_t              occ_o
);

  logic [DATA_W-1:0] mem_q [RD_BUF_DEPTH];
  occ_t              wptr_q, wptr_d;
  occ_t              rptr_q, rptr_d;
  occ_t              occ_q, occ_d;
  logic              rd_ok;

  // A read of an empty buffer is ignored; a write alongside it still lands.
  assign rd_ok = rd_i && (occ_q != occ_t'(0));

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (wr_i) begin
      wptr_d = ptr_inc(wptr_q);
    end
    if (rd_ok) begin
      rptr_d = ptr_inc(rptr_q);
    end
    occ_d = occ_q + {1'b0, wr_i} - {1'b0, rd_ok};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      if (wr_i) begin
        mem_q[wptr_q] <= wdata_i;
      end
    end
  end

  // Head is forced to zero when empty so the stream data never shows stale words.
  assign rdata_o = (occ_q != occ_t'(0)) ? mem_q[rptr_q] : '0;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains the byte FIFO into a valid/ready stream, 1 word/cycle
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W  = FIFO_DATA_W,
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               fifo_empty_i,
  input  logic [DATA_W-1:0]  fifo_dout_i,
  output logic               fifo_rd_en_o,
  output logic [DATA_W-1:0]  m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [COUNT_W-1:0] rd_count_o,
  output logic               idle_o
);

  logic               inflight_q;
  logic [COUNT_W-1:0] rd_count_q, rd_count_d;
  occ_t               occ;
  logic [2:0]         pending;
  logic               handshake;

  // Issue only when the buffer can take every word already requested plus this one,
  // so m_ready never reaches the read-enable path.
  assign pending      = {1'b0, occ} + {2'b00, inflight_q};
  assign fifo_rd_en_o = en_i && !fifo_empty_i && !rst_i && (pending < 3'(RD_BUF_DEPTH));

  assign m_valid_o = (occ != occ_t'(0));
  assign handshake = m_valid_o && m_ready_i;

  rd_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_i    (inflight_q),
    .wdata_i (fifo_dout_i),
    .rd_i    (handshake),
    .rdata_o (m_data_o),
    .occ_o   (occ)
  );

  always_comb begin
    rd_count_d = rd_count_q;
    if (handshake) begin
      rd_count_d = rd_count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      rd_count_q <= '0;
    end else begin
      inflight_q <= fifo_rd_en_o;
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_count_o = rd_count_q;
  assign idle_o     = (occ == occ_t'(0)) && !inflight_q && fifo_empty_i;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - randomized self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, en, m_ready;
  logic          fifo_empty, fifo_rd_en, m_valid, idle;
  logic [DW-1:0] fifo_dout = '0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] rd_count;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(DW), .COUNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .fifo_empty_i (fifo_empty),
    .fifo_dout_i  (fifo_dout),
    .fifo_rd_en_o (fifo_rd_en),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .rd_count_o   (rd_count),
    .idle_o       (idle)
  );

  // Source FIFO: array with push/pop pointers, registered read data.
  logic [7:0] fmem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } ent_t;

  ent_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   hs_total = 0;
  int   cnt_model = 0;
  int   rd_pulses = 0;
  bit   mon_on = 1'b0;
  bit   prev_stall = 1'b0;
  bit   ev;
  logic [7:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic fifo_push(input logic [7:0] d);
    fmem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: every popped word is owed to the consumer in order, visible two cycles
  // after its pop; at most three words may be owed at once.
  always @(negedge clk) begin
    if (mon_on) begin
      ev = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
      chk("rd_en", fifo_rd_en, en && !fifo_empty && !rst && (exp_q.size() < 3));
      chk("m_valid", m_valid, ev);
      if (ev) chk("m_data", m_data, exp_q[0].data);
      chk("rd_count", rd_count, cnt_model % 16);
      chk("idle", idle, (exp_q.size() == 0) && fifo_empty);
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      prev_stall = m_valid && !m_ready && !rst;
      prev_data  = m_data;
      if (fifo_rd_en) rd_pulses++;
      if (!rst && ev && m_ready) begin
        void'(exp_q.pop_front());
        hs_total++;
        cnt_model++;
      end
      if (fifo_rd_en) exp_q.push_back('{fmem[rd_ptr], cyc});
      if (rst) begin
        exp_q.delete();
        cnt_model = 0;
      end
    end
  end

  int  pushed;
  int  base;
  bit  found;

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    tick(2);
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    chk("idle_after_rst", idle, 1);
    tick(1);

    // 1: three words, consumer always ready
    rd_pulses = 0;
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
    en = 1'b1; m_ready = 1'b1;
    #1 chk("t1_rd_en_c0", fifo_rd_en, 1);
    tick(8);
    @(negedge clk);
    chk("t1_pulses", rd_pulses, 3);
    chk("t1_rd_count", rd_count, 3);
    chk("t1_idle", idle, 1);
    tick(1);

    // 2: stalled consumer fills the buffer, then drains without gaps
    m_ready = 1'b0; rd_pulses = 0;
    for (int i = 1; i <= 5; i++) fifo_push(8'(8'h11 * i));
    tick(10);
    @(negedge clk);
    chk("t2_pulses", rd_pulses, 3);
    chk("t2_m_valid", m_valid, 1);
    chk("t2_head", m_data, 8'h11);
    tick(1);
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("t2_seq_valid", m_valid, 1);
      chk("t2_seq_data", m_data, 8'(8'h11 * i));
    end
    tick(4);
    chk("t2_rd_count", rd_count, 8);

    // 3: empty FIFO never read
    rd_pulses = 0;
    tick(20);
    @(negedge clk);
    chk("t3_pulses", rd_pulses, 0);
    chk("t3_m_valid", m_valid, 0);
    chk("t3_idle", idle, 1);
    tick(1);

    // 4: en dropped right after a pop
    en = 1'b0;
    for (int i = 1; i <= 4; i++) fifo_push(8'(8'hA0 + i));
    tick(2);
    rd_pulses = 0;
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(8);
    @(negedge clk);
    chk("t4_pulses", rd_pulses, 1);
    chk("t4_rd_count", rd_count, 9);
    tick(1);
    en = 1'b1;
    tick(10);
    @(negedge clk);
    chk("t4_rd_count_end", rd_count, 12);
    chk("t4_idle", idle, 1);
    tick(1);

    // 5: reset with two buffered words and one in flight
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) fifo_push(8'(8'hB0 + i));
    tick(3);
    chk("t5_full_rd_en", fifo_rd_en, 0);
    chk("t5_full_valid", m_valid, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_m_valid", m_valid, 0);
    chk("t5_rd_count", rd_count, 0);
    m_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_valid) begin
        found = 1'b1;
        chk("t5_resume_data", m_data, 8'hB4);
      end
    end
    chk("t5_resume_seen", found, 1);
    tick(10);
    chk("t5_rd_count_end", rd_count, 3);

    // 6: counter wrap, then long randomized run
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) fifo_push(8'(i + 8'h40));
    tick(30);
    chk("t6_wrap", rd_count, 1);
    chk("t6_idle", idle, 1);

    base = hs_total;
    pushed = 0;
    for (int c = 0; c < 30000 && (hs_total - base) < 1000; c++) begin
      en      = ($urandom_range(0, 7) != 0);
      m_ready = $urandom_range(0, 1);
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        fifo_push(8'($urandom));
        pushed++;
      end
      tick(1);
    end
    chk("rand_words", hs_total - base, 1000);
    tick(3);
    chk("rand_idle", idle, 1);

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
